// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and types for the three-port register file
package reg_file_pkg;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_NREGS  = 32;
    localparam int ZERO_REG       = 0;
    typedef logic [DEFAULT_DATA_W-1:0] regWord_t;
endpackage

// File: rtl/reg_file_rdport.sv
// reg_file_rdport: one combinational read port with zero-register mux and optional write bypass
module reg_file_rdport
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = 5,
    parameter int WR_BYPASS = 0
) (
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] stored,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);
    logic isZero;
    logic hit;
    assign isZero = ra == ADDR_W'(ZERO_REG);
    assign hit    = (WR_BYPASS != 0) && we && (wa == ra);
    assign rd     = isZero ? '0 : hit ? wd : stored;
endmodule

// File: rtl/reg_file_3port.sv
// reg_file_3port: two async read ports, one sync write port, register 0 reads as zero
module reg_file_3port
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NREGS     = DEFAULT_NREGS,
    parameter int ADDR_W    = $clog2(NREGS),
    parameter int WR_BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] regs [NREGS];
    logic writeEn;
    logic bypassEn;
    assign writeEn  = we3 && (wa3 != ADDR_W'(ZERO_REG));
    // bypass is suppressed while reset is held so reads stay zero
    assign bypassEn = we3 && rst_n;
    // async clear of all entries; entry 0 is never written afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (writeEn) begin
            regs[wa3] <= wd3;
        end
    end
    reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WR_BYPASS(WR_BYPASS)) port1 (
        .ra(ra1), .stored(regs[ra1]), .we(bypassEn), .wa(wa3), .wd(wd3), .rd(rd1)
    );
    reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WR_BYPASS(WR_BYPASS)) port2 (
        .ra(ra2), .stored(regs[ra2]), .we(bypassEn), .wa(wa3), .wd(wd3), .rd(rd2)
    );
endmodule

// File: tb/tb_reg_file_3port.sv
// tb_reg_file_3port: scoreboard bench driving a plain and a bypassing instance in parallel
module tb_reg_file_3port;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we3;
    logic [4:0]  ra1, ra2, wa3;
    logic [31:0] wd3;
    logic [31:0] rd1, rd2, rd1b, rd2b;

    typedef struct {
        string       name;
        logic [31:0] e1, e2, e1b, e2b;
    } exp_t;

    exp_t q[$];
    event ev;
    int   checks = 0;
    int   failures = 0;

    reg_file_3port #(.WR_BYPASS(0)) dut (
        .clk(clk), .rst_n(rst_n), .we3(we3), .ra1(ra1), .ra2(ra2),
        .wa3(wa3), .wd3(wd3), .rd1(rd1), .rd2(rd2)
    );
    reg_file_3port #(.WR_BYPASS(1)) dutb (
        .clk(clk), .rst_n(rst_n), .we3(we3), .ra1(ra1), .ra2(ra2),
        .wa3(wa3), .wd3(wd3), .rd1(rd1b), .rd2(rd2b)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string n, input string p, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s got=%h exp=%h t=%0t", n, p, act, exp, $time);
        end
    endtask

    // monitor: samples 1ns after each request and drains the expectation queue
    initial begin
        exp_t e;
        forever begin
            @ev;
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "rd1", rd1, e.e1);
                cmp(e.name, "rd2", rd2, e.e2);
                cmp(e.name, "rd1_byp", rd1b, e.e1b);
                cmp(e.name, "rd2_byp", rd2b, e.e2b);
            end
        end
    end

    task automatic probe(input string n, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [31:0] e1b, input logic [31:0] e2b);
        exp_t e;
        e.name = n; e.e1 = e1; e.e2 = e2; e.e1b = e1b; e.e2b = e2b;
        q.push_back(e);
        ->ev;
        #2;
    endtask

    task automatic chk(input string n, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] e1b, input logic [31:0] e2b);
        probe(n, e1, e2, e1b, e2b);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we3 = 1'b1; wa3 = a; wd3 = d;
        @(negedge clk);
        we3 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we3 = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
        @(negedge clk);
        // write attempted while reset is held must be lost
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'd99;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            chk("rst_held", 0, 0, 0, 0);
        end
        we3 = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            chk("post_rst", 0, 0, 0, 0);
        end
        wr(5'd2, 32'd12);
        ra1 = 5'd2; ra2 = 5'd3;
        chk("basic_wr2", 12, 0, 12, 0);
        wr(5'd3, 32'hDEADBEEF);
        chk("basic_wr3", 12, 32'hDEADBEEF, 12, 32'hDEADBEEF);
        we3 = 1'b0; wa3 = 5'd5; wd3 = 32'h55;
        repeat (3) @(negedge clk);
        ra1 = 5'd5;
        chk("we_gate", 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        wr(5'd0, 32'hFFFFFFFF);
        ra1 = 5'd0;
        chk("zero_reg", 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        wr(5'd7, 32'd1);
        ra1 = 5'd7; ra2 = 5'd7;
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'd9;
        chk("rdw_pre", 1, 1, 9, 9);
        we3 = 1'b0;
        chk("rdw_post", 9, 9, 9, 9);
        ra1 = 5'd0;
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'd5;
        chk("rdw_zero", 0, 9, 0, 9);
        we3 = 1'b0;
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 3));
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'((i * 7) % 32);
            probe("dual_diff", 32'(i * 3), 32'(((i * 7) % 32) * 3), 32'(i * 3), 32'(((i * 7) % 32) * 3));
            ra2 = 5'(i);
            probe("dual_same", 32'(i * 3), 32'(i * 3), 32'(i * 3), 32'(i * 3));
            @(negedge clk);
        end
        ra1 = 5'd5; ra2 = 5'd31;
        #2 rst_n = 1'b0;
        probe("async_rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i += 4) begin
            ra1 = 5'(i); ra2 = 5'(i + 3);
            chk("after_async", 0, 0, 0, 0);
        end
        wr(5'd4, 32'd44);
        ra1 = 5'd4; ra2 = 5'd5;
        chk("post_rst_wr", 44, 0, 44, 0);
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/reg_file_3port.md
Name: reg_file_3port

Overview:
- Three-port general-purpose register file for the processor datapath: two asynchronous read ports and one synchronous write port.
- Sits between the instruction decoder, which supplies the register addresses, and the ALU/writeback stage, which supplies the write data.
- Register 0 is hardwired to zero, RISC-style.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- NREGS, 32, number of architectural registers; must be a power of two, at least 2.
- ADDR_W, $clog2(NREGS) (default 5), width of each address port.
- WR_BYPASS, 0, when 1 a read of the register being written this cycle returns wd3 instead of the stored value.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we3  input  1  write enable for port 3.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- wa3  input  ADDR_W  write address, port 3.
- wd3  input  DATA_W  write data, port 3.
- rd1  output  DATA_W  read data, port 1.
- rd2  output  DATA_W  read data, port 2.

Behaviour:
- Storage: NREGS x DATA_W flops. Entry 0 is not stored, or is stored and ignored; it always reads as 0.
- Reset:
  - rst_n low asynchronously clears entries 1..NREGS-1 to 0, with no dependence on clk.
  - rd1 and rd2 therefore read 0 while reset is held.
  - Deassertion takes effect at the next rising clk edge; integration synchronizes its release externally.
- Write:
  - On a rising clk edge with rst_n=1, we3=1 and wa3!=0, entry[wa3] <= wd3.
  - we3=0 or wa3=0: no state change. A write to register 0 is silently discarded.
- Read:
  - Purely combinational: rd1 = (ra1==0) ? 0 : entry[ra1]; rd2 is computed the same way from ra2.
  - Zero-cycle latency: outputs follow address changes within the same cycle.
- Read-during-write, same address:
  - WR_BYPASS=0: rd shows the old value until the edge and the new value immediately after.
  - WR_BYPASS=1: rd shows wd3 combinationally whenever we3=1, wa3==ra, and ra!=0.
- Both read ports may address the same register simultaneously; each returns the identical value.
- Reset asserted mid-cycle while we3=1: reset wins; the entry is 0 and the write is lost.
- Unknown or X addresses: no requirement beyond not corrupting other entries. Writes occur only under the defined we3/wa3 condition.
- No handshake and no stall; the block is always ready.

Decomposition:
- Package reg_file_pkg holds:
  - localparams DEFAULT_DATA_W=32, DEFAULT_NREGS=32;
  - the ZERO_REG=0 constant;
  - the typedef for a register word, logic [DATA_W-1:0].
- No sub-module needed. If desired, a single reg_file_rdport (address decode, zero-mux, optional bypass) is instantiated twice.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles, sweep ra1/ra2 over 0..31 -> rd1=rd2=0 everywhere. Then release rst_n, and all registers still read 0.
- Basic write/read: we3=1, wa3=2, wd3=32'd12 for one edge; then we3=0, ra1=2, ra2=3 -> rd1=12, rd2=0. Write wa3=3, wd3=32'hDEADBEEF -> ra2=3 gives DEADBEEF, and rd1 stays 12.
- Write-enable gating: we3=0, wa3=5, wd3=32'h55 for 3 edges -> ra1=5 reads 0. Register 0: we3=1, wa3=0, wd3=32'hFFFFFFFF -> ra1=0 reads 0.
- Read-during-write: reg 7 holds 1; we3=1, wa3=7, wd3=9, ra1=7.
  - WR_BYPASS=0: rd1=1 before the edge, 9 after.
  - WR_BYPASS=1: rd1=9 before the edge.
- Dual-port/async read: write all regs 1..31 with value i*3. Both ports read the same and different addresses without any clock edge -> rd1=ra1*3 and rd2=ra2*3, settling within the same cycle.
- Async reset mid-operation: after the regs are loaded, pulse rst_n low for 2 ns between clock edges -> all reads 0 immediately, with no clk edge required. A subsequent write to reg 4 with value 44 succeeds.
